// File: rtl/video_mnist_color_mapper_if.sv
// Bundle of the pixel stream (input and output sides) and the Wishbone
// register port of video_mnist_color_mapper.
interface video_mnist_color_mapper_if #(
  parameter int TUSER_WIDTH   = 1,
  parameter int TNUMBER_WIDTH = 4,
  parameter int TCOUNT_WIDTH  = 1,
  parameter int WB_ADR_WIDTH  = 8,
  parameter int WB_DAT_WIDTH  = 32
);
  logic [TUSER_WIDTH-1:0]    s_axi4s_tuser;
  logic                      s_axi4s_tlast;
  logic [TNUMBER_WIDTH-1:0]  s_axi4s_tnumber;
  logic [TCOUNT_WIDTH-1:0]   s_axi4s_tcount;
  logic [31:0]               s_axi4s_tdata;
  logic                      s_axi4s_tbinary;
  logic                      s_axi4s_tvalid;
  logic                      s_axi4s_tready;

  logic [TUSER_WIDTH-1:0]    m_axi4s_tuser;
  logic                      m_axi4s_tlast;
  logic [31:0]               m_axi4s_tdata;
  logic                      m_axi4s_tvalid;
  logic                      m_axi4s_tready;

  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i;
  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i;
  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o;
  logic                      s_wb_we_i;
  logic [WB_DAT_WIDTH/8-1:0] s_wb_sel_i;
  logic                      s_wb_stb_i;
  logic                      s_wb_ack_o;

  // Colour mapper side.
  modport slave (
    input  s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tnumber, s_axi4s_tcount,
    input  s_axi4s_tdata, s_axi4s_tbinary, s_axi4s_tvalid,
    output s_axi4s_tready,
    output m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata, m_axi4s_tvalid,
    input  m_axi4s_tready,
    input  s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
    output s_wb_dat_o, s_wb_ack_o
  );

  // Upstream source, downstream sink and bus master side.
  modport master (
    output s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tnumber, s_axi4s_tcount,
    output s_axi4s_tdata, s_axi4s_tbinary, s_axi4s_tvalid,
    input  s_axi4s_tready,
    input  m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata, m_axi4s_tvalid,
    output m_axi4s_tready,
    output s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
    input  s_wb_dat_o, s_wb_ack_o
  );
endinterface

// File: rtl/video_mnist_color_mapper.sv
// Per-digit palette overlay for the MNIST segmentation stream, one register stage.
// Define VIDEO_MNIST_COLOR_SHADOW_EN to make settings take effect only at frame start.
module video_mnist_color_mapper #(
  parameter int         DATA_WIDTH      = 8,
  parameter int         TUSER_WIDTH     = 1,
  parameter int         TNUMBER_WIDTH   = 4,
  parameter int         TCOUNT_WIDTH    = 1,
  parameter int         WB_ADR_WIDTH    = 8,
  parameter int         WB_DAT_WIDTH    = 32,
  parameter logic [1:0] INIT_PARAM_MODE = 2'b10,
  parameter int         INIT_PARAM_TH   = 1
) (
  input logic                   aresetn,
  input logic                   aclk,
  video_mnist_color_mapper_if.slave bus
);

  localparam int PIX_W      = 3 * DATA_WIDTH;
  localparam int NUM_COLORS = 10;
  localparam int NUM_BYTES  = WB_DAT_WIDTH / 8;

  localparam logic [WB_ADR_WIDTH-1:0] ADR_CORE_ID = WB_ADR_WIDTH'(8'h00);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_VERSION = WB_ADR_WIDTH'(8'h01);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_MODE    = WB_ADR_WIDTH'(8'h04);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_TH      = WB_ADR_WIDTH'(8'h05);
  localparam int                      ADR_PAL0    = 'h10;

  localparam logic [WB_DAT_WIDTH-1:0] CORE_ID = WB_DAT_WIDTH'(32'h4D4E_434C);
  localparam logic [WB_DAT_WIDTH-1:0] VERSION = WB_DAT_WIDTH'(32'h0001_0000);

  typedef logic [PIX_W-1:0]        rgb_t;
  typedef logic [WB_DAT_WIDTH-1:0] word_t;

  function automatic rgb_t default_color(input int idx);
    case (idx)
      0:       return rgb_t'(24'h000000);
      1:       return rgb_t'(24'h8B4513);
      2:       return rgb_t'(24'hFF0000);
      3:       return rgb_t'(24'hFFA500);
      4:       return rgb_t'(24'hFFFF00);
      5:       return rgb_t'(24'h00FF00);
      6:       return rgb_t'(24'h0000FF);
      7:       return rgb_t'(24'h800080);
      8:       return rgb_t'(24'h808080);
      default: return rgb_t'(24'hFFFFFF);
    endcase
  endfunction

  // Byte-lane merge of write data into the zero-extended current register value.
  function automatic word_t merge(input word_t old, input word_t wdat, input word_t mask);
    return (old & ~mask) | (wdat & mask);
  endfunction

  logic [1:0]              mode_reg;
  logic [TCOUNT_WIDTH-1:0] th_reg;
  rgb_t                    pal_reg [NUM_COLORS];

  word_t be_mask;
  logic  wr_en;

  always_comb begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      be_mask[i*8 +: 8] = {8{bus.s_wb_sel_i[i]}};
    end
  end

  assign wr_en = bus.s_wb_stb_i && bus.s_wb_we_i;

  // NOTE: the palette is a handful of flops, not a RAM, so it takes an async
  // reset to its default colours like any other register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mode_reg <= INIT_PARAM_MODE;
      th_reg   <= TCOUNT_WIDTH'(INIT_PARAM_TH);
      for (int i = 0; i < NUM_COLORS; i++) pal_reg[i] <= default_color(i);
    end else if (wr_en) begin
      // NOTE: non-blocking updates, so a pixel accepted this cycle sees the old value.
      if (bus.s_wb_adr_i == ADR_MODE)
        mode_reg <= 2'(merge(word_t'(mode_reg), bus.s_wb_dat_i, be_mask));
      if (bus.s_wb_adr_i == ADR_TH)
        th_reg <= TCOUNT_WIDTH'(merge(word_t'(th_reg), bus.s_wb_dat_i, be_mask));
      for (int i = 0; i < NUM_COLORS; i++) begin
        if (bus.s_wb_adr_i == WB_ADR_WIDTH'(ADR_PAL0 + i))
          pal_reg[i] <= PIX_W'(merge(word_t'(pal_reg[i]), bus.s_wb_dat_i, be_mask));
      end
    end
  end

  word_t rdata;

  // NOTE: rdata gets a default before the decode so no address path infers a latch.
  always_comb begin
    rdata = '0;
    case (bus.s_wb_adr_i)
      ADR_CORE_ID: rdata = CORE_ID;
      ADR_VERSION: rdata = VERSION;
      ADR_MODE:    rdata = word_t'(mode_reg);
      ADR_TH:      rdata = word_t'(th_reg);
      default: begin
        for (int i = 0; i < NUM_COLORS; i++) begin
          if (bus.s_wb_adr_i == WB_ADR_WIDTH'(ADR_PAL0 + i)) rdata = word_t'(pal_reg[i]);
        end
      end
    endcase
  end

  assign bus.s_wb_dat_o = rdata;
  assign bus.s_wb_ack_o = bus.s_wb_stb_i;

  logic s_ready;
  logic accept;

  logic                   m_valid;
  logic [TUSER_WIDTH-1:0] m_user;
  logic                   m_last;
  logic [31:0]            m_data;

  assign s_ready = !m_valid || bus.m_axi4s_tready;
  assign accept  = bus.s_axi4s_tvalid && s_ready;

  logic [1:0]              eff_mode;
  logic [TCOUNT_WIDTH-1:0] eff_th;
  rgb_t                    eff_pal [NUM_COLORS];

`ifdef VIDEO_MNIST_COLOR_SHADOW_EN
  logic [1:0]              sh_mode;
  logic [TCOUNT_WIDTH-1:0] sh_th;
  rgb_t                    sh_pal [NUM_COLORS];
  logic                    frame_load;

  assign frame_load = accept && bus.s_axi4s_tuser[0];

  // The frame-start pixel itself already uses the freshly loaded settings.
  always_comb begin
    eff_mode = frame_load ? mode_reg : sh_mode;
    eff_th   = frame_load ? th_reg   : sh_th;
    for (int i = 0; i < NUM_COLORS; i++) eff_pal[i] = frame_load ? pal_reg[i] : sh_pal[i];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sh_mode <= INIT_PARAM_MODE;
      sh_th   <= TCOUNT_WIDTH'(INIT_PARAM_TH);
      for (int i = 0; i < NUM_COLORS; i++) sh_pal[i] <= default_color(i);
    end else if (frame_load) begin
      sh_mode <= mode_reg;
      sh_th   <= th_reg;
      for (int i = 0; i < NUM_COLORS; i++) sh_pal[i] <= pal_reg[i];
    end
  end
`else
  always_comb begin
    eff_mode = mode_reg;
    eff_th   = th_reg;
    for (int i = 0; i < NUM_COLORS; i++) eff_pal[i] = pal_reg[i];
  end
`endif

  rgb_t base;
  rgb_t color;

  always_comb begin
    if (eff_mode[0]) base = bus.s_axi4s_tbinary ? '1 : '0;
    else             base = bus.s_axi4s_tdata[PIX_W-1:0];
    color = base;
    // Digit classes 10 and up never match a palette slot and fall back to base.
    if (eff_mode[1] && (bus.s_axi4s_tcount >= eff_th)) begin
      for (int i = 0; i < NUM_COLORS; i++) begin
        if (32'(bus.s_axi4s_tnumber) == 32'(i)) color = eff_pal[i];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid <= 1'b0;
      m_user  <= '0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_user  <= bus.s_axi4s_tuser;
      m_last  <= bus.s_axi4s_tlast;
      m_data  <= {bus.s_axi4s_tdata[31:PIX_W], color};
    end else if (bus.m_axi4s_tready) begin
      m_valid <= 1'b0;
    end
  end

  assign bus.s_axi4s_tready = s_ready;
  assign bus.m_axi4s_tvalid = m_valid;
  assign bus.m_axi4s_tuser  = m_user;
  assign bus.m_axi4s_tlast  = m_last;
  assign bus.m_axi4s_tdata  = m_data;

endmodule

// File: tb/tb_video_mnist_color_mapper.sv
// Scoreboard bench for video_mnist_color_mapper: directed pixels, register
// accesses, backpressure, a 640-wide multi-line frame and mid-stream reset.
module tb_video_mnist_color_mapper;

  localparam int LINE_W  = 640;
  localparam int LINES   = 4;
  localparam int WAIT_MAX = 200;

  typedef struct packed {
    logic        tuser;
    logic        tlast;
    logic [31:0] tdata;
  } beat_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic bp_en = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int rx_cnt = 0;
  beat_t sb[$];
  beat_t mon_e;

  video_mnist_color_mapper_if bus ();

  video_mnist_color_mapper dut (
    .aresetn (aresetn),
    .aclk    (aclk),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every beat the sink accepts is matched against the scoreboard head.
  always @(negedge aclk) begin
    if (aresetn && bus.m_axi4s_tvalid && bus.m_axi4s_tready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("m_tdata", bus.m_axi4s_tdata, mon_e.tdata);
        check("m_tuser", 32'(bus.m_axi4s_tuser), 32'(mon_e.tuser));
        check("m_tlast", 32'(bus.m_axi4s_tlast), 32'(mon_e.tlast));
        rx_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drive_px(input logic tuser, input logic tlast, input logic [3:0] tnum,
                          input logic tcnt, input logic tbin, input logic [31:0] tdata);
    bus.s_axi4s_tuser   = tuser;
    bus.s_axi4s_tlast   = tlast;
    bus.s_axi4s_tnumber = tnum;
    bus.s_axi4s_tcount  = tcnt;
    bus.s_axi4s_tbinary = tbin;
    bus.s_axi4s_tdata   = tdata;
    bus.s_axi4s_tvalid  = 1'b1;
  endtask

  // Entered and left just after a rising edge; returns once the pixel is taken.
  task automatic wait_accept();
    logic acc;
    logic done;
    done = 1'b0;
    for (int n = 0; n < WAIT_MAX && !done; n++) begin
      @(negedge aclk);
      acc = bus.s_axi4s_tready;
      @(posedge aclk);
      #1;
      if (bp_en) bus.m_axi4s_tready = ($urandom_range(0, 3) != 0);
      done = acc;
    end
    check("accept_in_time", 32'(done), 32'd1);
    bus.s_axi4s_tvalid = 1'b0;
  endtask

  task automatic send_px(input logic tuser, input logic tlast, input logic [3:0] tnum,
                         input logic tcnt, input logic tbin, input logic [31:0] tdata,
                         input logic [31:0] exp);
    sb.push_back(beat_t'{tuser: tuser, tlast: tlast, tdata: exp});
    drive_px(tuser, tlast, tnum, tcnt, tbin, tdata);
    wait_accept();
  endtask

  task automatic drain();
    for (int n = 0; n < WAIT_MAX && sb.size() != 0; n++) begin
      @(posedge aclk);
      #1;
    end
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus.s_wb_adr_i = adr;
    bus.s_wb_dat_i = dat;
    bus.s_wb_sel_i = sel;
    bus.s_wb_we_i  = 1'b1;
    bus.s_wb_stb_i = 1'b1;
    @(negedge aclk);
    check("wb_ack_wr", 32'(bus.s_wb_ack_o), 32'd1);
    @(posedge aclk);
    #1;
    bus.s_wb_stb_i = 1'b0;
    bus.s_wb_we_i  = 1'b0;
  endtask

  task automatic wb_read(input string name, input logic [7:0] adr, input logic [31:0] exp);
    bus.s_wb_adr_i = adr;
    bus.s_wb_we_i  = 1'b0;
    bus.s_wb_sel_i = 4'hF;
    bus.s_wb_stb_i = 1'b1;
    @(negedge aclk);
    check(name, bus.s_wb_dat_o, exp);
    check("wb_ack_rd", 32'(bus.s_wb_ack_o), 32'd1);
    @(posedge aclk);
    #1;
    bus.s_wb_stb_i = 1'b0;
  endtask

  initial begin
    int rx0;
    bus.s_axi4s_tuser = '0;   bus.s_axi4s_tlast = 1'b0;
    bus.s_axi4s_tnumber = '0; bus.s_axi4s_tcount = '0;
    bus.s_axi4s_tdata = '0;   bus.s_axi4s_tbinary = 1'b0;
    bus.s_axi4s_tvalid = 1'b0; bus.m_axi4s_tready = 1'b1;
    bus.s_wb_adr_i = '0; bus.s_wb_dat_i = '0; bus.s_wb_we_i = 1'b0;
    bus.s_wb_sel_i = '0; bus.s_wb_stb_i = 1'b0;

    repeat (3) @(posedge aclk);
    #1;
    check("rst_m_tvalid", 32'(bus.m_axi4s_tvalid), 32'd0);
    check("rst_m_tdata", bus.m_axi4s_tdata, 32'h0);
    check("rst_m_tuser", 32'(bus.m_axi4s_tuser), 32'd0);
    check("rst_m_tlast", 32'(bus.m_axi4s_tlast), 32'd0);
    check("rst_s_tready", 32'(bus.s_axi4s_tready), 32'd1);
    check("idle_ack", 32'(bus.s_wb_ack_o), 32'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Register defaults and read-only / unmapped locations.
    wb_read("rd_core_id", 8'h00, 32'h4D4E434C);
    wb_read("rd_version", 8'h01, 32'h00010000);
    wb_read("rd_mode_rst", 8'h04, 32'h2);
    wb_read("rd_th_rst", 8'h05, 32'h1);
    wb_read("rd_pal1_rst", 8'h11, 32'h008B4513);
    wb_read("rd_pal9_rst", 8'h19, 32'h00FFFFFF);
    wb_read("rd_unmapped", 8'h02, 32'h0);
    wb_read("rd_past_pal", 8'h1A, 32'h0);

    // Default MODE=10, TH=1: palette overlay gated by confidence and class.
    send_px(1'b1, 1'b0, 4'd2,  1'b1, 1'b0, 32'h00202020, 32'h00FF0000);
    send_px(1'b0, 1'b0, 4'd2,  1'b0, 1'b0, 32'h00202020, 32'h00202020);
    send_px(1'b0, 1'b0, 4'd12, 1'b1, 1'b0, 32'h00202020, 32'h00202020);
    send_px(1'b0, 1'b0, 4'd9,  1'b1, 1'b0, 32'h00202020, 32'h00FFFFFF);
    send_px(1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 32'h55202020, 32'h55000000);
    drain();

    // Binary background only.
    wb_write(8'h04, 32'h1, 4'hF);
    send_px(1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 32'h00202020, 32'h00FFFFFF);
    send_px(1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 32'h00202020, 32'h00000000);
    send_px(1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 32'hAB202020, 32'hAB000000);
    drain();

    // Overlay on binary background.
    wb_write(8'h04, 32'h3, 4'hF);
    send_px(1'b1, 1'b0, 4'd4,  1'b1, 1'b0, 32'h00202020, 32'h00FFFF00);
    send_px(1'b0, 1'b0, 4'd4,  1'b0, 1'b1, 32'h00202020, 32'h00FFFFFF);
    send_px(1'b0, 1'b0, 4'd10, 1'b1, 1'b0, 32'h00202020, 32'h00000000);
    drain();

    // TH=0 makes every pixel confident.
    wb_write(8'h04, 32'h2, 4'hF);
    wb_write(8'h05, 32'h0, 4'hF);
    send_px(1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 32'h00202020, 32'h0000FF00);
    drain();
    wb_read("rd_th_0", 8'h05, 32'h0);
    wb_write(8'h05, 32'h1, 4'h0);
    wb_read("rd_th_nosel", 8'h05, 32'h0);
    wb_write(8'h05, 32'h1, 4'h1);
    wb_read("rd_th_1", 8'h05, 32'h1);

    // Byte enables and ignored writes.
    wb_write(8'h13, 32'h00123456, 4'b0001);
    wb_read("rd_pal3_be", 8'h13, 32'h00FFA556);
    wb_write(8'h07, 32'hFFFFFFFF, 4'hF);
    wb_read("rd_unmapped_wr", 8'h07, 32'h0);
    wb_write(8'h00, 32'h12345678, 4'hF);
    wb_read("rd_core_id_wr", 8'h00, 32'h4D4E434C);

    // Palette change mid-frame.
    send_px(1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 32'h00202020, 32'h00FF0000);
    drain();
    wb_write(8'h12, 32'h000000FF, 4'hF);
`ifdef VIDEO_MNIST_COLOR_SHADOW_EN
    send_px(1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 32'h00202020, 32'h00FF0000);
`else
    send_px(1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 32'h00202020, 32'h000000FF);
`endif
    send_px(1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 32'h00202020, 32'h000000FF);
    drain();

    // Backpressure: output held while the sink stalls.
    bus.m_axi4s_tready = 1'b0;
    send_px(1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 32'h00111111, 32'h000000FF);
    sb.push_back(beat_t'{tuser: 1'b0, tlast: 1'b0, tdata: 32'h00800080});
    drive_px(1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 32'h00000000);
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      check("bp_s_tready", 32'(bus.s_axi4s_tready), 32'd0);
      check("bp_m_tvalid", 32'(bus.m_axi4s_tvalid), 32'd1);
      check("bp_m_tdata", bus.m_axi4s_tdata, 32'h000000FF);
      check("bp_m_tuser", 32'(bus.m_axi4s_tuser), 32'd1);
      check("bp_m_tlast", 32'(bus.m_axi4s_tlast), 32'd1);
      @(posedge aclk);
      #1;
    end
    bus.m_axi4s_tready = 1'b1;
    wait_accept();
    drain();

    // Frame of LINES lines, 640 pixels each, random gaps and sink stalls.
    rx0 = rx_cnt;
    bp_en = 1'b1;
    for (int y = 0; y < LINES; y++) begin
      for (int x = 0; x < LINE_W; x++) begin
        int idx;
        idx = y * LINE_W + x;
        if ($urandom_range(0, 7) == 0) begin
          @(posedge aclk);
          #1;
        end
        send_px(idx == 0, x == LINE_W - 1, 4'(idx), 1'b0, 1'b0,
                {8'hC3, 24'(idx)}, {8'hC3, 24'(idx)});
      end
    end
    bp_en = 1'b0;
    bus.m_axi4s_tready = 1'b1;
    drain();
    check("frame_rx_count", 32'(rx_cnt - rx0), 32'(LINE_W * LINES));

    // Reset while a beat is pending at the output.
    wb_write(8'h04, 32'h1, 4'hF);
    bus.m_axi4s_tready = 1'b0;
    drive_px(1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 32'h00ABCDEF);
    wait_accept();
    check("pre_rst_m_tvalid", 32'(bus.m_axi4s_tvalid), 32'd1);
    aresetn = 1'b0;
    #1;
    check("mid_rst_m_tvalid", 32'(bus.m_axi4s_tvalid), 32'd0);
    check("mid_rst_m_tdata", bus.m_axi4s_tdata, 32'h0);
    check("mid_rst_s_tready", 32'(bus.s_axi4s_tready), 32'd1);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    bus.m_axi4s_tready = 1'b1;
    wb_read("rd_mode_rst2", 8'h04, 32'h2);
    wb_read("rd_pal2_rst2", 8'h12, 32'h00FF0000);
    wb_read("rd_pal3_rst2", 8'h13, 32'h00FFA500);
    send_px(1'b1, 1'b1, 4'd8, 1'b1, 1'b0, 32'h00202020, 32'h00808080);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
